// File: rtl/rsa_pkg.sv
// Shared defaults, FSM encoding and latency constants for the RSA decrypt engine.
package rsa_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int TAG_W_DEF  = 5;
  localparam int MODMUL_LAT = WIDTH_DEF + 1;
  localparam int MODEXP_LAT = 1 + (WIDTH_DEF + 1) * (WIDTH_DEF + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    EXP    = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/rsa_mod_mul.sv
// MSB-first interleaved modular multiplier: p = a*b mod n, WIDTH+1 cycles start->done.
module rsa_mod_mul
  import rsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int RW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] STEPS = CW'(WIDTH);

  logic [WIDTH-1:0] a_reg, b_reg, n_reg;
  logic [RW-1:0]    r_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg, done_reg;

  logic [RW-1:0] n_ext, add_val, r_dbl, r_sub1, r_next;

  // 2r + a < 3n, so two conditional subtractions always bring r back below n
  always_comb begin
    n_ext   = {2'b00, n_reg};
    add_val = b_reg[WIDTH-1] ? {2'b00, a_reg} : '0;
    r_dbl   = (r_reg << 1) + add_val;
    r_sub1  = (r_dbl >= n_ext) ? r_dbl - n_ext : r_dbl;
    r_next  = (r_sub1 >= n_ext) ? r_sub1 - n_ext : r_sub1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      n_reg    <= '0;
      r_reg    <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        a_reg    <= a;
        b_reg    <= b;
        n_reg    <= n;
        r_reg    <= '0;
        cnt_reg  <= STEPS;
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        r_reg   <= r_next;
        b_reg   <= b_reg << 1;
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done = done_reg;
  assign p    = r_reg[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp_decrypt.sv
// Fixed-latency RSA decrypt m = c^d mod n, right-to-left square-and-multiply over all WIDTH bits of d.
module rsa_modexp_decrypt
  import rsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_n,
  input  logic [WIDTH-1:0] in_d,
  input  logic [WIDTH-1:0] in_c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_m,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] n_reg, d_reg, c_reg, base_reg, result_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [IW-1:0]    i_reg;
  logic             start_reg;
  logic             in_ready_reg, out_valid_reg, out_err_reg;
  logic [WIDTH-1:0] out_m_reg;
  logic [TAG_W-1:0] out_tag_reg;

  logic [WIDTH-1:0] mul_a [2];
  logic [WIDTH-1:0] mul_b [2];
  logic [WIDTH-1:0] mul_p [2];
  logic [1:0]       mul_done;
  logic             both_done;

  // During REDUCE both units compute 1*c mod n; in EXP unit 0 multiplies, unit 1 squares
  assign mul_a[0] = (state_reg == REDUCE) ? WIDTH'(1) : result_reg;
  assign mul_b[0] = (state_reg == REDUCE) ? c_reg : base_reg;
  assign mul_a[1] = (state_reg == REDUCE) ? WIDTH'(1) : base_reg;
  assign mul_b[1] = (state_reg == REDUCE) ? c_reg : base_reg;
  assign both_done = &mul_done;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mul
      rsa_mod_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (start_reg),
        .a     (mul_a[gi]),
        .b     (mul_b[gi]),
        .n     (n_reg),
        .done  (mul_done[gi]),
        .p     (mul_p[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      n_reg         <= '0;
      d_reg         <= '0;
      c_reg         <= '0;
      tag_reg       <= '0;
      base_reg      <= '0;
      result_reg    <= '0;
      i_reg         <= '0;
      start_reg     <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_m_reg     <= '0;
      out_tag_reg   <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            n_reg        <= in_n;
            d_reg        <= in_d;
            c_reg        <= in_c;
            tag_reg      <= in_tag;
            i_reg        <= '0;
            in_ready_reg <= 1'b0;
            if (in_n == '0) begin
              out_valid_reg <= 1'b1;
              out_m_reg     <= '0;
              out_err_reg   <= 1'b1;
              out_tag_reg   <= in_tag;
              state_reg     <= DONE;
            end else begin
              start_reg <= 1'b1;
              state_reg <= REDUCE;
            end
          end
        end
        REDUCE: begin
          if (both_done) begin
            base_reg   <= mul_p[0];
            result_reg <= (n_reg == WIDTH'(1)) ? '0 : WIDTH'(1);
            start_reg  <= 1'b1;
            state_reg  <= EXP;
          end
        end
        EXP: begin
          if (both_done) begin
            if (d_reg[i_reg]) result_reg <= mul_p[0];
            base_reg <= mul_p[1];
            if (i_reg == LAST_BIT) begin
              out_valid_reg <= 1'b1;
              out_m_reg     <= d_reg[i_reg] ? mul_p[0] : result_reg;
              out_err_reg   <= 1'b0;
              out_tag_reg   <= tag_reg;
              state_reg     <= DONE;
            end else begin
              i_reg     <= i_reg + 1'b1;
              start_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_m     = out_m_reg;
  assign out_tag   = out_tag_reg;
  assign out_err   = out_err_reg;

endmodule

// File: tb/tb_rsa_modexp_decrypt.sv
// Bench for rsa_modexp_decrypt: directed/random vector table, backpressure and mid-operation reset.
module tb_rsa_modexp_decrypt;

  localparam int LAT_EDGES = 1122;  // out_valid is seen 1122 edges after the accept edge (1123-cycle latency)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_n = '0, in_d = '0, in_c = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_m;
  logic [4:0]  out_tag;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rsa_modexp_decrypt dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_n(in_n), .in_d(in_d), .in_c(in_c), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_m(out_m), .out_tag(out_tag), .out_err(out_err)
  );

  typedef struct {
    logic [31:0] n;
    logic [31:0] d;
    logic [31:0] c;
    logic [4:0]  tag;
    logic [31:0] m;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ref_modexp(input logic [31:0] n, input logic [31:0] d,
                                             input logic [31:0] c);
    longint unsigned nn, r, b;
    if (n == 0) return 32'd0;
    nn = {32'd0, n};
    r  = 64'd1 % nn;
    b  = {32'd0, c} % nn;
    for (int k = 0; k < 32; k++) begin
      if (d[k]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[31:0];
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_n = v.n; in_d = v.d; in_c = v.c; in_tag = v.tag;
    in_valid = 1'b1;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Offers v, waits (bounded) for acceptance, then measures edges until out_valid
  task automatic send_and_wait(input vec_t v, output int lat);
    int w;
    @(negedge clk);
    drive(v);
    w = 0;
    while (!in_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
  endtask

  task automatic check_result(input vec_t v, input int lat, input int idx);
    $display("txn %0d: n=0x%08h d=0x%08h c=0x%08h tag=%0d -> m=0x%08h tag=%0d err=%0d lat=%0d",
             idx, v.n, v.d, v.c, v.tag, out_m, out_tag, out_err, lat);
    check("out_valid", out_valid, 1);
    check("out_m", out_m, v.m);
    check("out_tag", out_tag, v.tag);
    check("out_err", out_err, v.err);
    check("latency", lat, (v.n == 0) ? 0 : LAT_EDGES);
  endtask

  initial begin
    int lat;
    vec_t va, vb, vr;

    vecs.push_back('{n: 32'd3233, d: 32'd2753, c: 32'd2790, tag: 5'd7, m: 32'd65, err: 1'b0});
    vecs.push_back('{n: 32'd3233, d: 32'd2753, c: 32'd6023, tag: 5'd3, m: 32'd65, err: 1'b0});
    vecs.push_back('{n: 32'd3233, d: 32'd0,    c: 32'd1234, tag: 5'd1, m: 32'd1,  err: 1'b0});
    vecs.push_back('{n: 32'd1,    d: 32'd5,    c: 32'd9,    tag: 5'd2, m: 32'd0,  err: 1'b0});
    vecs.push_back('{n: 32'd0,    d: 32'd77,   c: 32'd55,   tag: 5'd9, m: 32'd0,  err: 1'b1});
    vecs.push_back('{n: 32'hFFFFFFFB, d: 32'hFFFFFFFA, c: 32'd2, tag: 5'd4, m: 32'd1, err: 1'b0});
    vecs.push_back('{n: 32'd3233, d: 32'd17,   c: 32'd0,    tag: 5'd5, m: 32'd0,  err: 1'b0});
    for (int k = 0; k < 5; k++) begin
      vr.n = $urandom;
      if (k == 0) vr.n[31] = 1'b1;
      if (vr.n == 0) vr.n = 32'd97;
      vr.d   = $urandom;
      vr.c   = $urandom;
      vr.tag = 5'($urandom_range(0, 31));
      vr.m   = ref_modexp(vr.n, vr.d, vr.c);
      vr.err = 1'b0;
      vecs.push_back(vr);
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_m", out_m, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_err", out_err, 0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      send_and_wait(vecs[k], lat);
      check_result(vecs[k], lat, k);
    end

    // Backpressure: hold the result 50 cycles while a second tuple is offered
    va = vecs[0];
    vb = vecs[1];
    vb.tag = 5'd21;
    @(negedge clk);
    out_ready = 1'b0;
    send_and_wait(va, lat);
    check_result(va, lat, 100);
    drive(vb);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_m", out_m, va.m);
      check("bp_out_tag", out_tag, va.tag);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    check_result(vb, lat, 101);

    // Reset asserted 500 cycles into an operation
    @(negedge clk);
    drive(vecs[5]);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (499) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("postrst_out_valid", out_valid, 0);
    check("postrst_in_ready", in_ready, 1);
    send_and_wait(vecs[0], lat);
    check_result(vecs[0], lat, 102);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
